// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// 8N1 UART transmitter with a built-in baud counter. One byte is accepted per
// request and serialized as: start bit (low), 8 data bits LSB first, stop bit
// (high). The line idles high.
//
// Ports
//   sysclk    in   1  system clock, all state changes on the rising edge
//   reset     in   1  asynchronous, active-high reset
//   tx_data   in   8  byte to send, sampled only on the accept edge
//   tx_start  in   1  level-sensitive request, honoured only while idle
//   UART_TX   out  1  serial line, driven straight from a flop
//   tx_busy   out  1  high from the cycle after accept until the frame ends
//   tx_done   out  1  one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DIVISOR  = CLK_FREQ / BAUD   // sysclk cycles per bit, >= 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       UART_TX,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  logic             w_baud_last;

  assign w_baud_last = (r_baud_cnt == CNT_LAST);

  // The line level, busy and done flags are computed from the next state and
  // registered alongside it, so every output comes directly from a flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= 8'hFF;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (tx_start) begin
            r_shift    <= tx_data;
            r_baud_cnt <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= r_shift[0];
            r_state    <= ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            r_shift    <= {1'b1, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              // Next bit is shift[1] now, shift[0] after this edge.
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign UART_TX = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Self-checking bench for uart_transmitter. A fast instance (DIVISOR=16) is
// exercised per scenario; a default-parameter instance checks the bit period.
// Each accepted byte pushes its expected 10-bit line pattern to a queue; the
// pattern is popped and compared when the recorded line is decoded.
// Cycle numbering: the accept edge is cycle 0, the sample taken at the falling
// edge after it is cycle 1.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int D     = 16;
  localparam int DEF_D = 10416;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       UART_TX, tx_busy, tx_done;

  logic [7:0] def_data;
  logic       def_start;
  logic       def_tx, def_busy, def_done;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  logic rec_line [1:512];
  logic rec_busy [1:512];
  logic rec_done [1:512];

  uart_transmitter #(.DIVISOR(D)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .UART_TX (UART_TX),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  uart_transmitter dut_def (
    .sysclk  (sysclk),
    .reset   (reset),
    .tx_data (def_data),
    .tx_start(def_start),
    .UART_TX (def_tx),
    .tx_busy (def_busy),
    .tx_done (def_done)
  );

  always #5 sysclk = ~sysclk;

  // Samples the fast DUT outputs for cycles 1..n (caller sits at cycle 1).
  task automatic record(input int n);
    for (int c = 1; c <= n; c++) begin
      rec_line[c] = UART_TX;
      rec_busy[c] = tx_busy;
      rec_done[c] = tx_done;
      @(negedge sysclk);
    end
  endtask

  // Request one byte; returns at the falling edge of cycle 1.
  task automatic send(input logic [7:0] d);
    @(negedge sysclk);
    tx_data  = d;
    tx_start = 1'b1;
    exp_q.push_back({1'b1, d, 1'b0});
    @(negedge sysclk);
    tx_start = 1'b0;
  endtask

  // Line model: cycles of a frame starting at cycle s that differ from pat.
  function automatic int frame_mismatches(input int s, input logic [9:0] pat);
    int m = 0;
    for (int c = 0; c < 10 * D; c++)
      if (rec_line[s + c] !== pat[c / D]) m++;
    return m;
  endfunction

  // Receiver model: samples each data bit at its centre.
  function automatic logic [7:0] decode(input int s);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) d[k] = rec_line[s + (k + 1) * D + D / 2 - 1];
    return d;
  endfunction

  function automatic int count_ones(input int a, input int b, input int which);
    int n = 0;
    for (int c = a; c <= b; c++) begin
      if (which == 0 && rec_line[c] === 1'b1) n++;
      if (which == 1 && rec_busy[c] === 1'b1) n++;
      if (which == 2 && rec_done[c] === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic test_reset;
    reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    def_start = 1'b0; def_data = 8'h00;
    #1;
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_line_async: got %b expected 1", UART_TX); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_async: got %b expected 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done_async: got %b expected 0", tx_done); end
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL idle_line: got %b expected 1", UART_TX); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL idle_done: got %b expected 0", tx_done); end
  endtask

  task automatic test_basic_frame;
    logic [9:0] pat;
    send(8'hA5);
    record(200);
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL basic_queue: got empty expected 1 entry"); pat = '1; end
    else pat = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rec_line[i * D + D / 2] !== pat[i]) begin
        errors++; $display("FAIL basic_bit%0d: got %b expected %b", i, rec_line[i * D + D / 2], pat[i]);
      end
    end
    checks++; if (frame_mismatches(1, pat) != 0) begin errors++; $display("FAIL basic_shape: got %0d bad cycles expected 0", frame_mismatches(1, pat)); end
    checks++; if (count_ones(1, 200, 1) != 160 || rec_busy[160] !== 1'b1) begin errors++; $display("FAIL basic_busy_len: got %0d expected 160", count_ones(1, 200, 1)); end
    checks++; if (rec_done[161] !== 1'b1) begin errors++; $display("FAIL basic_done_161: got %b expected 1", rec_done[161]); end
    checks++; if (count_ones(1, 200, 2) != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", count_ones(1, 200, 2)); end
  endtask

  task automatic test_edge_bytes;
    logic [9:0] pat;
    int run;
    logic [7:0] bytes [2];
    int lows [2];
    bytes[0] = 8'h00; bytes[1] = 8'hFF;
    lows[0] = 9 * D;  lows[1] = D;
    for (int b = 0; b < 2; b++) begin
      send(bytes[b]);
      record(170);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL edge_queue: got empty expected 1 entry"); pat = '1; end
      else pat = exp_q.pop_front();
      checks++; if (frame_mismatches(1, pat) != 0) begin errors++; $display("FAIL edge_shape_%02h: got %0d bad cycles expected 0", bytes[b], frame_mismatches(1, pat)); end
      checks++; if (decode(1) !== pat[8:1]) begin errors++; $display("FAIL edge_decode: got %02h expected %02h", decode(1), pat[8:1]); end
      run = 0;
      while (run < 170 && rec_line[run + 1] === 1'b0) run++;
      checks++; if (run != lows[b]) begin errors++; $display("FAIL edge_low_run_%02h: got %0d expected %0d", bytes[b], run, lows[b]); end
    end
  endtask

  task automatic test_busy_rejection;
    logic [9:0] pat;
    send(8'h3C);
    fork
      record(300);
      begin
        repeat (49) @(negedge sysclk);
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        @(negedge sysclk);
        tx_start = 1'b0;
        repeat (29) @(negedge sysclk);
        tx_data  = 8'h99;
      end
    join
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL busy_queue: got empty expected 1 entry"); pat = '1; end
    else pat = exp_q.pop_front();
    checks++; if (frame_mismatches(1, pat) != 0) begin errors++; $display("FAIL busy_shape: got %0d bad cycles expected 0", frame_mismatches(1, pat)); end
    checks++; if (decode(1) !== 8'h3C) begin errors++; $display("FAIL busy_decode: got %02h expected 3c", decode(1)); end
    checks++; if (count_ones(1, 300, 2) != 1 || rec_done[161] !== 1'b1) begin errors++; $display("FAIL busy_done_once: got %0d pulses expected 1", count_ones(1, 300, 2)); end
    checks++; if (count_ones(161, 300, 0) != 140) begin errors++; $display("FAIL busy_no_second_frame: got %0d high cycles expected 140", count_ones(161, 300, 0)); end
    checks++; if (count_ones(161, 300, 1) != 0) begin errors++; $display("FAIL busy_idle_after: got %0d busy cycles expected 0", count_ones(161, 300, 1)); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] pat;
    @(negedge sysclk);
    tx_data  = 8'h12;
    tx_start = 1'b1;
    exp_q.push_back({1'b1, 8'h12, 1'b0});
    @(negedge sysclk);
    fork
      record(400);
      begin
        repeat (4) @(negedge sysclk);
        tx_data = 8'h34;
        exp_q.push_back({1'b1, 8'h34, 1'b0});
        repeat (195) @(negedge sysclk);
        tx_start = 1'b0;
      end
    join
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_queue1: got empty expected entry"); pat = '1; end
    else pat = exp_q.pop_front();
    checks++; if (frame_mismatches(1, pat) != 0) begin errors++; $display("FAIL b2b_frame1: got %0d bad cycles expected 0", frame_mismatches(1, pat)); end
    checks++; if (rec_line[161] !== 1'b1 || rec_done[161] !== 1'b1 || rec_busy[161] !== 1'b0) begin errors++; $display("FAIL b2b_gap: got line=%b done=%b busy=%b expected 1 1 0", rec_line[161], rec_done[161], rec_busy[161]); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_queue2: got empty expected entry"); pat = '1; end
    else pat = exp_q.pop_front();
    checks++; if (frame_mismatches(162, pat) != 0) begin errors++; $display("FAIL b2b_frame2: got %0d bad cycles expected 0", frame_mismatches(162, pat)); end
    checks++; if (decode(162) !== 8'h34) begin errors++; $display("FAIL b2b_decode2: got %02h expected 34", decode(162)); end
    checks++; if (count_ones(1, 400, 2) != 2 || rec_done[322] !== 1'b1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", count_ones(1, 400, 2)); end
    checks++; if (count_ones(322, 400, 0) != 79) begin errors++; $display("FAIL b2b_no_third: got %0d high cycles expected 79", count_ones(322, 400, 0)); end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] pat;
    send(8'h55);
    repeat (69) @(negedge sysclk);
    #2 reset = 1'b1;
    #1;
    checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL midreset_line: got %b expected 1", UART_TX); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", tx_busy); end
    exp_q.delete();
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    record(40);
    checks++; if (count_ones(1, 40, 2) != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", count_ones(1, 40, 2)); end
    checks++; if (count_ones(1, 40, 0) != 40) begin errors++; $display("FAIL midreset_idle_line: got %0d high cycles expected 40", count_ones(1, 40, 0)); end
    send(8'h0F);
    record(170);
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL midreset_queue: got empty expected 1 entry"); pat = '1; end
    else pat = exp_q.pop_front();
    checks++; if (frame_mismatches(1, pat) != 0) begin errors++; $display("FAIL midreset_fresh_frame: got %0d bad cycles expected 0", frame_mismatches(1, pat)); end
    checks++; if (decode(1) !== 8'h0F) begin errors++; $display("FAIL midreset_decode: got %02h expected 0f", decode(1)); end
    checks++; if (rec_done[161] !== 1'b1 || count_ones(1, 170, 2) != 1) begin errors++; $display("FAIL midreset_done: got %0d pulses expected 1 at cycle 161", count_ones(1, 170, 2)); end
  endtask

  task automatic test_default_divisor;
    int n;
    @(negedge sysclk);
    def_data  = 8'hFF;
    def_start = 1'b1;
    @(negedge sysclk);
    def_start = 1'b0;
    checks++; if (def_busy !== 1'b1) begin errors++; $display("FAIL default_busy: got %b expected 1", def_busy); end
    n = 0;
    while (def_tx === 1'b0 && n < DEF_D + 100) begin
      n++;
      @(negedge sysclk);
    end
    checks++; if (n != DEF_D) begin errors++; $display("FAIL default_bit_period: got %0d cycles expected %0d", n, DEF_D); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_edge_bytes();
    test_busy_rejection();
    test_back_to_back();
    test_reset_mid_frame();
    test_default_divisor();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drained: got %0d entries expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
